// File: rtl/isa_pkg.sv
// Instruction word layout and opcode legality shared by the encoder and the
// controlunit decoder.
package isa_pkg;

    localparam int WORD_W   = 32;
    localparam int OPC_LSB  = 28;
    localparam int OPC_W    = 4;
    localparam int A1_LSB   = 23;
    localparam int A2_LSB   = 18;
    localparam int A3_LSB   = 13;
    localparam int REG_W    = 5;
    localparam int FLAG_LSB = 9;
    localparam int FLAG_W   = 4;
    localparam int PAR_BIT  = 8;
    localparam int NUM_LSB  = 0;
    localparam int NUM_W    = 8;

    localparam logic [OPC_W-1:0] OPC_ILLEGAL_E = 4'hE;
    localparam logic [OPC_W-1:0] OPC_ILLEGAL_F = 4'hF;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  addr1;
        logic [REG_W-1:0]  addr2;
        logic [REG_W-1:0]  addr3;
        logic [FLAG_W-1:0] flag;
        logic              parity;
        logic [NUM_W-1:0]  number;
    } instr_t;

    function automatic logic opc_illegal(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ILLEGAL_E) || (opc == OPC_ILLEGAL_F);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two circular FIFO holding encoded instruction words.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into a 32-bit word with optional even parity,
// drops illegal opcodes with an error pulse, and queues legal words.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             opcode,
    input  logic [4:0]             addr1,
    input  logic [4:0]             addr2,
    input  logic [4:0]             addr3,
    input  logic [3:0]             theflag,
    input  logic [7:0]             number,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    instr_t      fields;
    logic [31:0] word;
    logic [31:0] fifo_q;
    logic        live;
    logic        accept;
    logic        illegal;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_comb begin
        fields.opcode = opcode;
        fields.addr1  = addr1;
        fields.addr2  = addr2;
        fields.addr3  = addr3;
        fields.flag   = theflag;
        fields.number = number;
        fields.parity = 1'b0;
        if (PARITY_EN != 0)
            fields.parity = ^{opcode, addr1, addr2, addr3, theflag, number};
    end

    assign word    = fields;
    assign illegal = opc_illegal(opcode);
    assign accept  = in_valid && in_ready;
    assign push    = accept && !illegal;
    assign pop     = out_valid && out_ready;

    // Holds in_ready low through reset until the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= accept && illegal;
    end

    assign in_ready  = live && !full;
    assign out_valid = !empty;
    assign out_word  = out_valid ? fifo_q : 32'h0;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (fifo_q),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule
